// File: rtl/instr_encoder_writer_pkg.sv
// Shared definitions for the RV32I instruction encoder/writer.
// Holds the instruction format enum, the error codes reported on err_code, a few
// opcode constants used by loaders and tests, and the signed-immediate fit check
// shared by the packer.
package instr_encoder_writer_pkg;

  // Instruction formats as presented on in_fmt; encodings 6 and 7 are invalid.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Reasons a bundle is rejected.
  localparam logic [1:0] ERR_BAD_FMT = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_ALIGN   = 2'd2;

  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_IMM    = 7'h13;

  // True when imm is the sign-extension of bit msb, i.e. bits [31:msb] are all equal.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] s;
    s = 32'($signed(imm) >>> msb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer.
// Takes a format plus the raw instruction fields and a 32-bit immediate, and
// produces the packed instruction word together with a range/alignment verdict.
//   fmt_i                  instruction format (see fmt_e), 6..7 rejected
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i   raw fields
//   imm_i                  signed immediate (U: full upper value)
//   word_o                 packed instruction (don't-care when err_o is set)
//   err_o, code_o          rejection flag and reason
module instr_field_packer
  import instr_encoder_writer_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o,
  output logic [1:0]  code_o
);

  fmt_e fmt_v;
  assign fmt_v = fmt_e'(fmt_i);

  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    code_o = ERR_BAD_FMT;
    case (fmt_v)
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!imm_fits(imm_i, 11)) begin
          err_o  = 1'b1;
          code_o = ERR_RANGE;
        end
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!imm_fits(imm_i, 11)) begin
          err_o  = 1'b1;
          code_o = ERR_RANGE;
        end
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                  opcode_i};
        // Range is reported in preference to misalignment.
        if (!imm_fits(imm_i, 12)) begin
          err_o  = 1'b1;
          code_o = ERR_RANGE;
        end else if (imm_i[0]) begin
          err_o  = 1'b1;
          code_o = ERR_ALIGN;
        end
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        // Low bits would be silently lost, so treat them as out of range.
        if (imm_i[11:0] != 12'h000) begin
          err_o  = 1'b1;
          code_o = ERR_RANGE;
        end
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (!imm_fits(imm_i, 20)) begin
          err_o  = 1'b1;
          code_o = ERR_RANGE;
        end else if (imm_i[0]) begin
          err_o  = 1'b1;
          code_o = ERR_ALIGN;
        end
      end
      default: begin
        err_o  = 1'b1;
        code_o = ERR_BAD_FMT;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Streaming RV32I instruction encoder and instruction-memory writer.
// Accepts field bundles over in_valid/in_ready, encodes and checks them in one
// combinational stage, and writes valid words to consecutive memory addresses
// through a single output register held until mem_ready.
//   clk, rst                  clock, synchronous active-high reset
//   start, start_addr         begin a run at start_addr (clears counters)
//   finish                    stop accepting, drain the output stage, pulse done
//   in_valid/in_ready, in_*   instruction field bundle
//   mem_we/mem_ready, mem_addr, mem_wdata   instruction-memory write port
//   err_valid, err_code       one-cycle pulse per rejected bundle
//   word_count, wrapped       words written since start (saturating), sticky wrap flag
//   busy, done                not idle, one-cycle pulse on drain completion
module instr_encoder_writer
  import instr_encoder_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  wrapped,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CountWidth = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [CountWidth-1:0] word_count_q, word_count_d;
  logic                  wrapped_q, wrapped_d;
  logic                  done_q, done_d;

  logic        pk_err;
  logic [1:0]  pk_code;
  logic [31:0] pk_word;
  logic        accept;
  logic        wr_hs;

  instr_field_packer u_packer (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pk_word),
    .err_o    (pk_err),
    .code_o   (pk_code)
  );

  // A new bundle may enter whenever the output register is empty or emptying.
  assign in_ready = (state_q == StRun) && (!mem_we_q || mem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_hs    = mem_we_q && mem_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;
    wrapped_d    = wrapped_q;
    done_d       = 1'b0;

    // addr_q always names the word currently presented (or the next one to load),
    // so advancing it on the handshake makes it the address of a word loaded this cycle.
    if (wr_hs) begin
      mem_we_d = 1'b0;
      addr_d   = addr_q + ADDR_WIDTH'(1);
      if (addr_q == '1) begin
        wrapped_d = 1'b1;
      end
      if (word_count_q != '1) begin
        word_count_d = word_count_q + CountWidth'(1);
      end
    end

    if (accept) begin
      if (pk_err) begin
        err_valid_d = 1'b1;
        err_code_d  = pk_code;
      end else begin
        mem_we_d    = 1'b1;
        mem_wdata_d = pk_word;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          addr_d       = start_addr;
          word_count_d = '0;
          wrapped_d    = 1'b0;
        end
      end
      StRun: begin
        // start has priority over finish; a restart is only honoured with nothing
        // pending so an in-flight word never lands at the new address.
        if (start) begin
          if (!mem_we_q) begin
            addr_d       = start_addr;
            word_count_d = '0;
            wrapped_d    = 1'b0;
          end
        end else if (finish) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!mem_we_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      word_count_q <= '0;
      wrapped_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
      wrapped_q    <= wrapped_d;
      done_q       <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;
  assign wrapped    = wrapped_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Self-checking bench for instr_encoder_writer: hand-computed vector table, directed
// multi-cycle sequences (stall, wrap/saturation on a 4-bit-address copy, drain, reset),
// and a randomized run checked against a behavioural encoder and write scoreboard.
module tb_instr_encoder_writer
  import instr_encoder_writer_pkg::*;
;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, mem_ready;
  logic [9:0]  start_addr;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, err_valid, wrapped, busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [10:0] word_count;

  logic        in_ready_s, mem_we_s, err_valid_s, wrapped_s, busy_s, done_s;
  logic [3:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [1:0]  err_code_s;
  logic [4:0]  word_count_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder_writer #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_valid(err_valid), .err_code(err_code),
    .word_count(word_count), .wrapped(wrapped), .busy(busy), .done(done)
  );

  instr_encoder_writer #(.ADDR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr[3:0]), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we_s), .mem_ready(mem_ready),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .err_valid(err_valid_s),
    .err_code(err_code_s), .word_count(word_count_s), .wrapped(wrapped_s), .busy(busy_s),
    .done(done_s)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          err;
    logic [1:0]  code;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(input logic [2:0] fmt, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input bit err,
                               input logic [1:0] code, input logic [31:0] word);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.err = err; v.code = code; v.word = word;
    return v;
  endfunction

  // Behavioural encoder: integer ranges and field arithmetic straight from the ISA tables.
  function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output bit err, output logic [1:0] code,
                                     output logic [31:0] word);
    longint s;
    longint unsigned u, w, vop, vrd, vrs1, vrs2, vf3, vf7;
    s = longint'($signed(imm));
    u = longint'(imm);
    vop = longint'(op); vrd = longint'(rd); vrs1 = longint'(rs1); vrs2 = longint'(rs2);
    vf3 = longint'(f3); vf7 = longint'(f7);
    err = 0; code = 2'd0; w = 0;
    case (fmt)
      3'd0: w = vf7 * (1 << 25) + vrs2 * (1 << 20) + vrs1 * (1 << 15) + vf3 * (1 << 12)
                + vrd * (1 << 7) + vop;
      3'd1, 3'd2: begin
        if (s < -2048 || s > 2047) begin err = 1; code = 2'd1; end
        if (fmt == 3'd1)
          w = (u % 4096) * (1 << 20) + vrs1 * (1 << 15) + vf3 * (1 << 12) + vrd * (1 << 7) + vop;
        else
          w = ((u / 32) % 128) * (1 << 25) + vrs2 * (1 << 20) + vrs1 * (1 << 15)
              + vf3 * (1 << 12) + (u % 32) * (1 << 7) + vop;
      end
      3'd3: begin
        if (s < -4096 || s > 4095) begin err = 1; code = 2'd1; end
        else if (s % 2 != 0) begin err = 1; code = 2'd2; end
        w = ((u / 4096) % 2) * (longint'(1) << 31) + ((u / 32) % 64) * (1 << 25)
            + vrs2 * (1 << 20) + vrs1 * (1 << 15) + vf3 * (1 << 12)
            + ((u / 2) % 16) * (1 << 8) + ((u / 2048) % 2) * (1 << 7) + vop;
      end
      3'd4: begin
        if (u % 4096 != 0) begin err = 1; code = 2'd1; end
        w = (u / 4096) * 4096 + vrd * (1 << 7) + vop;
      end
      3'd5: begin
        if (s < -1048576 || s > 1048575) begin err = 1; code = 2'd1; end
        else if (s % 2 != 0) begin err = 1; code = 2'd2; end
        w = ((u / 1048576) % 2) * (longint'(1) << 31) + ((u / 2) % 1024) * (1 << 21)
            + ((u / 2048) % 2) * (1 << 20) + ((u / 4096) % 256) * (1 << 12)
            + vrd * (1 << 7) + vop;
      end
      default: begin err = 1; code = 2'd0; end
    endcase
    word = w[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0]  exp_addr;
    logic [31:0] q[$];
    logic [31:0] mword, w;
    logic [1:0]  mcode, ncode;
    bit          acc, hs, merr, nerr;
    int          nvalid, exp_cnt, dones;

    rst = 1; start = 0; finish = 0; in_valid = 0; mem_ready = 0; start_addr = '0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    vecs[0]  = mkv(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, 2'd0, 32'h008000EF);
    vecs[1]  = mkv(FMT_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 0, 2'd0,
                   32'hFFF00293);
    vecs[2]  = mkv(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 0, 2'd0,
                   32'hFE000EE3);
    vecs[3]  = mkv(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 0, 2'd0, 32'h00000363);
    vecs[4]  = mkv(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1, 2'd2, 32'h0);
    vecs[5]  = mkv(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 1, 2'd1, 32'h0);
    vecs[6]  = mkv(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1, 2'd0, 32'h0);
    vecs[7]  = mkv(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 0, 2'd0, 32'h403100B3);
    vecs[8]  = mkv(FMT_S, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFFFFF8, 0, 2'd0,
                   32'hFE512C23);
    vecs[9]  = mkv(FMT_U, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 2'd0,
                   32'h12345537);
    vecs[10] = mkv(FMT_U, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1, 2'd1, 32'h0);
    vecs[11] = mkv(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 2'd1, 32'h0);
    vecs[12] = mkv(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 0, 2'd0,
                   32'h80000013);
    vecs[13] = mkv(FMT_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE, 0, 2'd0,
                   32'hFFFFF06F);
    vecs[14] = mkv(FMT_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1, 2'd2, 32'h0);
    vecs[15] = mkv(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4097, 1, 2'd1, 32'h0);
    vecs[16] = mkv(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1, 2'd0, 32'h0);

    // Reset state.
    tick(); tick();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Vector table at 0x10 with memory always ready.
    start = 1; start_addr = 10'h010; tick(); start = 0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(mem_addr), 32'h10);
    mem_ready = 1; exp_addr = 10'h010; nvalid = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3,
            vecs[i].f7, vecs[i].imm);
      in_valid = 1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 0;
      check($sformatf("vec%0d_err_valid", i), 32'(err_valid), 32'(vecs[i].err));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(!vecs[i].err));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(exp_addr));
      if (vecs[i].err) begin
        check($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].code));
      end else begin
        check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].word);
        exp_addr++;
        nvalid++;
      end
    end
    tick();
    check("table_word_count", 32'(word_count), 32'(nvalid));
    check("table_idle_we", 32'(mem_we), 32'd0);
    check("table_next_addr", 32'(mem_addr), 32'(exp_addr));

    // Stall: two bundles offered while memory is not ready; a restart is ignored.
    start = 1; start_addr = 10'h040; tick(); start = 0;
    check("restart_addr", 32'(mem_addr), 32'h40);
    check("restart_count", 32'(word_count), 32'd0);
    mem_ready = 0;
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1; tick();
    drive(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    start = 1; start_addr = 10'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_mem_we", 32'(mem_we), 32'd1);
      check("stall_wdata", mem_wdata, 32'h00500093);
      check("stall_addr", 32'(mem_addr), 32'h40);
      tick();
      start = 0;
    end
    mem_ready = 1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 0;
    check("release_addr", 32'(mem_addr), 32'h41);
    check("release_wdata", mem_wdata, 32'h00700113);
    check("release_we", 32'(mem_we), 32'd1);
    tick();
    check("release_count", 32'(word_count), 32'd2);
    check("release_we_off", 32'(mem_we), 32'd0);

    // start and finish together: start wins.
    start = 1; finish = 1; start_addr = 10'h080; tick(); start = 0; finish = 0;
    @(negedge clk);
    check("sf_busy", 32'(busy), 32'd1);
    check("sf_in_ready", 32'(in_ready), 32'd1);
    check("sf_addr", 32'(mem_addr), 32'h80);

    // Wrap on the 4-bit copy and word_count saturation.
    tick();
    start = 1; start_addr = 10'd15; tick(); start = 0;
    drive(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    in_valid = 1; tick();
    check("wrap_addr0_s", 32'(mem_addr_s), 32'd15);
    tick();
    check("wrap_addr1_s", 32'(mem_addr_s), 32'd0);
    check("wrap_flag_s", 32'(wrapped_s), 32'd1);
    check("wrap_addr1", 32'(mem_addr), 32'd16);
    check("wrap_flag", 32'(wrapped), 32'd0);
    repeat (33) tick();
    in_valid = 0; tick();
    check("sat_count_s", 32'(word_count_s), 32'd31);
    check("sat_count", 32'(word_count), 32'd35);
    check("sat_wrapped_s", 32'(wrapped_s), 32'd1);

    // finish with a write stuck behind mem_ready.
    mem_ready = 0;
    drive(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    in_valid = 1; tick(); in_valid = 0;
    finish = 1; tick(); finish = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check("drain_done", 32'(done), 32'd0);
      tick();
    end
    mem_ready = 1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) dones++;
    end
    check("drain_done_pulses", 32'(dones), 32'd1);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_we", 32'(mem_we), 32'd0);

    // Reset in the middle of a stalled write drops it.
    start = 1; start_addr = 10'h033; tick(); start = 0;
    mem_ready = 0; in_valid = 1; tick(); in_valid = 0;
    check("rststall_we", 32'(mem_we), 32'd1);
    rst = 1; tick(); rst = 0;
    check("rststall_we_off", 32'(mem_we), 32'd0);
    check("rststall_busy", 32'(busy), 32'd0);
    check("rststall_addr", 32'(mem_addr), 32'd0);
    mem_ready = 1; tick();
    check("rststall_dropped", 32'(mem_we), 32'd0);

    // Randomized run against the behavioural model.
    exp_addr = 10'($urandom); exp_cnt = 0; nerr = 0; ncode = 2'd0;
    start = 1; start_addr = exp_addr; tick(); start = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        int unsigned r, b;
        in_valid  = ($urandom_range(0, 9) < 7);
        mem_ready = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 15);
        in_fmt = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
        in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
        b = $urandom_range(0, 4);
        case (b)
          0: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
          2: in_imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
          3: in_imm = $urandom;
          default: in_imm = $urandom & 32'hFFFFF000;
        endcase
      end else begin
        in_valid = 0; mem_ready = 1;
      end
      @(negedge clk);
      check("rand_in_ready", 32'(in_ready), 32'((q.size() == 0) || mem_ready));
      acc = in_valid && in_ready;
      hs = mem_we && mem_ready;
      if (hs) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL rand_write: got write of 0x%0h expected none", mem_wdata);
        end else begin
          w = q.pop_front();
          check("rand_wdata", mem_wdata, w);
          check("rand_addr", 32'(mem_addr), 32'(exp_addr));
          exp_addr++;
          exp_cnt++;
        end
      end
      nerr = 0;
      if (acc) begin
        ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
                   merr, mcode, mword);
        if (merr) begin
          nerr = 1; ncode = mcode;
        end else begin
          q.push_back(mword);
        end
      end
      tick();
      check("rand_err_valid", 32'(err_valid), 32'(nerr));
      if (nerr) check("rand_err_code", 32'(err_code), 32'(ncode));
    end
    check("rand_drained", 32'(q.size()), 32'd0);
    check("rand_word_count", 32'(word_count), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the per-format instruction decoders.
- Accepts instruction fields (format, opcode, registers, funct, immediate) over a valid/ready handshake, range-checks the immediate, packs the 32-bit word, and writes it to consecutive instruction-memory words.
- Sits between the test-program loader / debug port and instruction memory. Used to build boot images and patch code at run time.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; the address wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: load start_addr, clear counters, enter RUN
- start_addr  in  ADDR_WIDTH  first word address
- finish  in  1  pulse: stop accepting input, drain, then signal done
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 invalid
- in_opcode  in  7  opcode[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  32  byte immediate, signed (U: full upper value)
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- err_valid  out  1  one-cycle pulse per rejected bundle
- err_code  out  2  0=bad fmt, 1=imm out of range, 2=imm misaligned
- word_count  out  ADDR_WIDTH+1  words written since start
- wrapped  out  1  sticky: address wrapped past the top of memory
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN→IDLE

Behaviour:
- Reset: state=IDLE; every output 0; address=0.
- States and transitions:
  - IDLE: start→RUN.
  - RUN: finish→DRAIN. start in RUN reloads the address and clears counters, but only when the output stage is empty; otherwise start is ignored.
  - DRAIN: output stage empty→IDLE with done=1 for one cycle.
  - start and finish in the same cycle: start wins.
- in_ready = (state==RUN) && (!mem_we || mem_ready). It is 0 in IDLE and DRAIN.
- Pipeline:
  - Stage 1 is a combinational encode plus check of the accepted bundle.
  - On the next edge, a valid result loads the output register (mem_we=1, mem_wdata, mem_addr=current address). An invalid result pulses err_valid/err_code and is not written.
  - Accept-to-mem_we latency: 1 cycle.
  - mem_we, mem_addr and mem_wdata hold stable until mem_ready.
  - Full throughput: 1 word/cycle while mem_ready=1.
- On a write handshake (mem_we && mem_ready):
  - address+1, wrapping to 0; wrapping sets wrapped.
  - word_count+1, saturating at its maximum.
- Encoding (imm bits are taken from in_imm):
  - R: f7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Checks (range check first; misalignment is reported only if the range check passes):
  - I, S: imm must be the sign-extension of bit 11.
  - B: sign-extension of bit 12, and imm[0]=0.
  - J: sign-extension of bit 20, and imm[0]=0.
  - U: imm[11:0] must be 0, reported as code 1 (out of range).
  - R: imm ignored.
- rst mid-operation: any pending write is dropped and state returns to IDLE.

Decomposition:
- Shared package (alongside ALU_OP_ENUM):
  - format enum (FMT_R..FMT_J)
  - error-code constants
  - opcode constants (OP_JAL=7'h6F, OP_BRANCH=7'h63, OP_IMM=7'h13)
- One combinational sub-module, instr_field_packer: takes fmt, fields and imm; outputs word, err and code. It can be unit-tested against the decoders in a round trip.

Test Plan:
- start with start_addr=0x10; J, op 0x6F, rd=1, imm=8 → mem_we next cycle, mem_addr=0x10, mem_wdata=0x008000EF.
- I, op 0x13, rd=5, rs1=0, f3=0, imm=-1 → 0xFFF00293. B, op 0x63, rs1=rs2=0, f3=0, imm=-4 → 0xFE000EE3 at the next address.
- B with imm=6 then imm=7 → first word written; second gives err_valid with code 2, no write, address unchanged. J with imm=0x100000 → code 1.
- Hold mem_ready=0 for 3 cycles with 2 bundles offered → in_ready=0, mem_wdata stable, no loss. Release → both words written on consecutive addresses; word_count=2.
- ADDR_WIDTH=4, start_addr=15, two writes → addresses 15 then 0; wrapped=1.
- finish while a write is pending with mem_ready=0 → busy stays 1; after mem_ready, done pulses once and state=IDLE. rst asserted mid-stall → mem_we=0 next cycle.
